// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: FK/CK constants, S-box and key-schedule FSM encoding.
// Used by both the key schedule and the encryption rounds so there is one S-box.
package sm4_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned KEY_W  = 128;
    localparam int unsigned ROUNDS = 32;
    localparam int unsigned CNT_W  = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // FK0 occupies the top word so it lines up with MK0 = key[127:96]
    localparam logic [KEY_W-1:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

    localparam logic [7:0] SBOX_TBL [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[x];
    endfunction

    // CK_i byte j (j = 0 is the most significant byte) = (4i + j) * 7 mod 256
    function automatic logic [WORD_W-1:0] ck(input logic [CNT_W-1:0] i);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            w[31-8*j -: 8] = 8'((int'(i) * 4 + j) * 7);
        end
        return w;
    endfunction

endpackage

// File: rtl/sm4_key_round.sv
// One SM4 key-expansion round: new = K0 ^ L'(tau(K1 ^ K2 ^ K3 ^ CK)).
module sm4_key_round
    import sm4_pkg::*;
(
    input  logic [WORD_W-1:0] k0_i,
    input  logic [WORD_W-1:0] k1_i,
    input  logic [WORD_W-1:0] k2_i,
    input  logic [WORD_W-1:0] k3_i,
    input  logic [WORD_W-1:0] ck_i,
    output logic [WORD_W-1:0] new_key_c
);

    logic [WORD_W-1:0] t;
    logic [WORD_W-1:0] b;

    always_comb begin
        t = k1_i ^ k2_i ^ k3_i ^ ck_i;
        b = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        new_key_c = k0_i ^ b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    end

endmodule

// File: rtl/sm4_key_sched.sv
// Iterative SM4 key expansion: one round key per clock into a 32-entry bank,
// then key_exp_out holds high until the next start, disable or reset.
module sm4_key_sched
    import sm4_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              sm4_enable,
    input  logic              key_start,
    input  logic [KEY_W-1:0]  key_in,
    output logic [WORD_W-1:0] rk_00, rk_01, rk_02, rk_03, rk_04, rk_05, rk_06, rk_07,
    output logic [WORD_W-1:0] rk_08, rk_09, rk_10, rk_11, rk_12, rk_13, rk_14, rk_15,
    output logic [WORD_W-1:0] rk_16, rk_17, rk_18, rk_19, rk_20, rk_21, rk_22, rk_23,
    output logic [WORD_W-1:0] rk_24, rk_25, rk_26, rk_27, rk_28, rk_29, rk_30, rk_31,
    output logic              key_exp_out,
    output logic              busy
);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [KEY_W-1:0]  win_q, win_d;
    logic              key_exp_q, key_exp_d;
    logic              busy_q, busy_d;
    logic [WORD_W-1:0] rk_q [ROUNDS];
    logic [ROUNDS-1:0] rk_we;
    logic [WORD_W-1:0] ck_c;
    logic [WORD_W-1:0] new_key_c;

    assign ck_c = ck(cnt_q);

    sm4_key_round u_round (
        .k0_i      (win_q[127:96]),
        .k1_i      (win_q[95:64]),
        .k2_i      (win_q[63:32]),
        .k3_i      (win_q[31:0]),
        .ck_i      (ck_c),
        .new_key_c (new_key_c)
    );

    // Next-state: load on start, shift the window each RUN cycle, abort on disable
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        rk_we   = '0;
        case (state_q)
            ST_IDLE: begin
                if (sm4_enable && key_start) begin
                    win_d   = key_in ^ FK;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!sm4_enable) begin
                    state_d = ST_IDLE;
                end else begin
                    rk_we = ROUNDS'(1) << cnt_q;
                    win_d = {win_q[95:0], new_key_c};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ROUNDS - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!sm4_enable) begin
                    state_d = ST_IDLE;
                end else if (key_start) begin
                    win_d   = key_in ^ FK;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        key_exp_d = (state_d == ST_DONE);
        busy_d    = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            win_q     <= '0;
            key_exp_q <= 1'b0;
            busy_q    <= 1'b0;
            for (int i = 0; i < ROUNDS; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            win_q     <= win_d;
            key_exp_q <= key_exp_d;
            busy_q    <= busy_d;
            for (int i = 0; i < ROUNDS; i++) begin
                if (rk_we[i]) begin
                    rk_q[i] <= new_key_c;
                end
            end
        end
    end

    assign key_exp_out = key_exp_q;
    assign busy        = busy_q;

    assign rk_00 = rk_q[0];   assign rk_01 = rk_q[1];   assign rk_02 = rk_q[2];   assign rk_03 = rk_q[3];
    assign rk_04 = rk_q[4];   assign rk_05 = rk_q[5];   assign rk_06 = rk_q[6];   assign rk_07 = rk_q[7];
    assign rk_08 = rk_q[8];   assign rk_09 = rk_q[9];   assign rk_10 = rk_q[10];  assign rk_11 = rk_q[11];
    assign rk_12 = rk_q[12];  assign rk_13 = rk_q[13];  assign rk_14 = rk_q[14];  assign rk_15 = rk_q[15];
    assign rk_16 = rk_q[16];  assign rk_17 = rk_q[17];  assign rk_18 = rk_q[18];  assign rk_19 = rk_q[19];
    assign rk_20 = rk_q[20];  assign rk_21 = rk_q[21];  assign rk_22 = rk_q[22];  assign rk_23 = rk_q[23];
    assign rk_24 = rk_q[24];  assign rk_25 = rk_q[25];  assign rk_26 = rk_q[26];  assign rk_27 = rk_q[27];
    assign rk_28 = rk_q[28];  assign rk_29 = rk_q[29];  assign rk_30 = rk_q[30];  assign rk_31 = rk_q[31];

endmodule

// File: tb/tb_sm4_key_sched.sv
// Directed bench for sm4_key_sched: standard vector, hold, restart, abort and reset.
module tb_sm4_key_sched;
    import sm4_pkg::*;

    localparam logic [127:0] STD_KEY = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

    logic         clk = 1'b0;
    logic         rst;
    logic         sm4_enable;
    logic         key_start;
    logic [127:0] key_in;
    logic [31:0]  rk [32];
    logic         key_exp_out;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_rk [32];

    always #5 clk = ~clk;

    sm4_key_sched dut (
        .clk(clk), .rst(rst), .sm4_enable(sm4_enable), .key_start(key_start), .key_in(key_in),
        .rk_00(rk[0]),  .rk_01(rk[1]),  .rk_02(rk[2]),  .rk_03(rk[3]),
        .rk_04(rk[4]),  .rk_05(rk[5]),  .rk_06(rk[6]),  .rk_07(rk[7]),
        .rk_08(rk[8]),  .rk_09(rk[9]),  .rk_10(rk[10]), .rk_11(rk[11]),
        .rk_12(rk[12]), .rk_13(rk[13]), .rk_14(rk[14]), .rk_15(rk[15]),
        .rk_16(rk[16]), .rk_17(rk[17]), .rk_18(rk[18]), .rk_19(rk[19]),
        .rk_20(rk[20]), .rk_21(rk[21]), .rk_22(rk[22]), .rk_23(rk[23]),
        .rk_24(rk[24]), .rk_25(rk[25]), .rk_26(rk[26]), .rk_27(rk[27]),
        .rk_28(rk[28]), .rk_29(rk[29]), .rk_30(rk[30]), .rk_31(rk[31]),
        .key_exp_out(key_exp_out), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Reference key expansion over the full K[0..35] sequence
    task automatic model(input logic [127:0] key);
        logic [31:0] k [36];
        logic [31:0] t, b, ckw;
        k[0] = key[127:96] ^ 32'hA3B1BAC6;
        k[1] = key[95:64]  ^ 32'h56AA3350;
        k[2] = key[63:32]  ^ 32'h677D9197;
        k[3] = key[31:0]   ^ 32'hB27022DC;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) begin
                ckw[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
            end
            t = k[i+1] ^ k[i+2] ^ k[i+3] ^ ckw;
            for (int j = 0; j < 4; j++) begin
                b[8*j +: 8] = sbox(t[8*j +: 8]);
            end
            k[i+4] = k[i] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
            exp_rk[i] = k[i+4];
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("%s_rk%02d", tag, i), rk[i], exp_rk[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start(input logic [127:0] key);
        key_in     = key;
        sm4_enable = 1'b1;
        key_start  = 1'b1;
        tick();
        key_start  = 1'b0;
    endtask

    // Count cycles from the start edge until key_exp_out rises (bounded)
    task automatic wait_done(input bit inject, output int cyc, output int bsy);
        cyc = 0;
        bsy = 0;
        while (key_exp_out !== 1'b1 && cyc < 40) begin
            bsy += int'(busy);
            key_start = inject && (cyc == 5 || cyc == 15);
            tick();
            cyc++;
        end
        key_start = 1'b0;
    endtask

    int cyc, bsy, busy_seen;

    initial begin
        rst = 1'b1; sm4_enable = 1'b0; key_start = 1'b0; key_in = '0;
        @(negedge clk);
        tick();
        chk("rst_key_exp", 32'(key_exp_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rk00", rk[0], 32'h0);
        chk("rst_rk31", rk[31], 32'h0);
        rst = 1'b0;

        // Standard vector with key_start pulses during RUN that must be ignored
        start(STD_KEY);
        wait_done(1'b1, cyc, bsy);
        chk("std_latency", 32'(cyc), 32'd32);
        chk("std_busy_cycles", 32'(bsy), 32'd32);
        chk("std_busy_done", 32'(busy), 32'd0);
        chk("std_rk00", rk[0], 32'hF12186F9);
        chk("std_rk01", rk[1], 32'h41662B61);
        chk("std_rk31", rk[31], 32'h9124A012);
        model(STD_KEY);
        check_all("std");

        // Hold: disabled, key_in toggling, key_start pulsed
        sm4_enable = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            key_start = 1'b1;
            tick();
            if (i == 0) chk("hold_key_exp_drop", 32'(key_exp_out), 32'd0);
            busy_seen += int'(busy);
        end
        key_start = 1'b0;
        chk("hold_busy", 32'(busy_seen), 32'd0);
        chk("hold_key_exp", 32'(key_exp_out), 32'd0);
        check_all("hold");

        // Restart from DONE with a zero key
        start(STD_KEY);
        wait_done(1'b0, cyc, bsy);
        chk("pre_restart_latency", 32'(cyc), 32'd32);
        start(128'h0);
        chk("restart_key_exp_fall", 32'(key_exp_out), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        wait_done(1'b0, cyc, bsy);
        chk("restart_latency", 32'(cyc), 32'd32);
        model(128'h0);
        check_all("zero");

        // Abort at round 10, then a full standard expansion
        start(STD_KEY);
        repeat (10) tick();
        sm4_enable = 1'b0;
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_key_exp", 32'(key_exp_out), 32'd0);
        repeat (3) tick();
        chk("abort_key_exp_hold", 32'(key_exp_out), 32'd0);
        start(STD_KEY);
        wait_done(1'b0, cyc, bsy);
        chk("after_abort_latency", 32'(cyc), 32'd32);
        model(STD_KEY);
        check_all("after_abort");

        // Reset in the middle of RUN
        start(STD_KEY);
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("midrst_rk%02d", i), rk[i], 32'h0);
        end
        chk("midrst_key_exp", 32'(key_exp_out), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
        tick();
        chk("midrst_stay_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
